asc_state_unit: RTL and testbench
=================================

# asc_state_unit

Multi-channel adaptation-speed-control state unit for the MCAC ADPCM codec. For each codeword it stores and updates the per-channel short-term average DMS, the long-term average DML and the speed-control parameter AP. It is the sequential owner of DML and AP: it reads the channel's state, runs the FUNCTF/FILTA/FILTB/SUBTC/FILTC/TRIGA update, and writes the result back. It sits between the codeword path (I, Y, TDP, TR) and the scale-factor limiter, which consumes AP.

## Interface
- NCH, 32, number of channels; per-channel state registers.
- CHW, 5, channel-index width, equal to clog2(NCH).
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  a codeword update request is present this cycle.
- CH  in  CHW  channel index, 0..NCH-1.
- I  in  4  ADPCM codeword; bit 3 is the sign.
- Y  in  13  quantizer scale factor for this sample.
- TDP  in  1  tone detect flag.
- TR  in  1  transition detect flag.
- AP_VALID  out  1  AP_OUT and APR_OUT are valid.
- AP_OUT  out  10  AP value for CH before the update; this is the value the limiter uses.
- APR_OUT  out  10  updated AP, as written back.

## Operation
- Reset: every channel sets DMS=0, DML=0 and AP=0. AP_VALID=0, AP_OUT=0, APR_OUT=0. Pipeline valid flags clear.
- Stage 0 (accept): when IN_VALID=1, register CH, I, Y, TDP and TR. There is no backpressure, and a new request may arrive every cycle.
- Stage 1 (read/compute/write): read DMS, DML and AP for the registered channel, with forwarding applied as described below. Compute the following, all in unsigned modular arithmetic:
  - IM: if I[3]=1, IM=(15−I)&7; otherwise IM=I&7.
  - FI, from IM 0..7: 0, 0, 0, 1, 1, 1, 3, 7.
  - DMSP = DMS + sx12(((FI<<9) + 2^13 − DMS) mod 2^13 >> 5), taken mod 2^12.
  - DMLP = DML + sx14(((FI<<11) + 2^15 − DML) mod 2^15 >> 7), taken mod 2^14.
  - Here sx means the shifted field keeps its sign bit: fill the upper bits with 1 when the difference MSB is set.
  - DIF = (DMSP<<2) − DMLP, taken as 15-bit signed. DIFM = |DIF|. DTHR = DMLP>>3.
  - AX = 0 when Y≥1536, DIFM<DTHR and TDP=0; otherwise AX = 1.
  - APP = AP + sx10(((AX<<9) + 2^11 − AP) mod 2^11 >> 4), taken mod 2^10.
  - APR = 256 if TR=1; otherwise APR = APP.
- Write back DMSP, DMLP and APR to the channel. Drive AP_OUT with the pre-update AP and APR_OUT with APR, and set AP_VALID=1.
- Forwarding: if the stage-1 channel equals the channel written in the previous cycle, use the just-written values rather than the register contents.
  - Back-to-back requests to one channel must behave exactly like sequential processing.
- CH≥NCH: the request is ignored. AP_VALID stays 0 and no state is written.
- Reset mid-operation: any in-flight request is discarded, and all state returns to its reset values.

## Timing
- Latency: IN_VALID at edge n gives AP_VALID=1 in the cycle after edge n+1. Outputs are registered.
- Throughput: one update per cycle.
- AP_VALID is a single-cycle pulse per accepted request.
- Output values hold until the next valid result; they do not return to 0.
- The state write and output capture happen on the same edge.

## Structure
- Package asc_pkg holds:
  - the width constants: DMS 12, DML 14, AP 10, Y 13;
  - the FI lookup constant;
  - the constants 1536 and 256.
- Sub-module asc_update is purely combinational. It takes (I, Y, TDP, TR, DMS, DML, AP) and produces (DMSP, DMLP, APR); it implements FUNCTF through TRIGA.
- The top level holds the state arrays, the two pipeline stages, forwarding and channel-range checking.

## Test plan
- Reset, then CH=3, I=7, Y=0, TDP=0, TR=0: AP_OUT=0, APR_OUT=32; channel 3 holds DMS=112 and DML=112.
- Issue the same request again on the very next cycle (forwarding): AP_OUT=32 and DML becomes 223 (112+111).
- From DML=112, send I=0 (FI=0) on that channel, a negative-difference case: DML becomes 111, because the −112>>7 shift yields −1.
- Send any request with TR=1: APR_OUT=256 regardless of AX.
- Hold DMS=DML=0, Y=1536 and TDP=0 (DIFM=0 is not below DTHR=0), then Y=1535: AX=1 in both cases. Then, with state preloaded by I sequences so that DIFM<DTHR and Y=2000, check that AX=0 and AP decays.
- Interleave channels 0 and 31, then send CH=32 and assert reset_n=0 mid-stream. The per-channel results must be independent. CH=32 must give no AP_VALID. After reset, all channels must read AP_OUT=0.

Source files
------------

// File: rtl/asc_pkg.sv
// asc_pkg: widths, FI lookup and thresholds shared by the adaptation-speed-control state unit
package asc_pkg;
  localparam int DMS_W = 12;
  localparam int DML_W = 14;
  localparam int AP_W  = 10;
  localparam int Y_W   = 13;
  localparam logic [Y_W-1:0]  Y_THR = 13'd1536;
  localparam logic [AP_W-1:0] AP_TR = 10'd256;
  localparam logic [2:0] FI_TAB [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd3, 3'd7};
endpackage

// File: rtl/asc_update.sv
// asc_update: combinational FUNCTF/FILTA/FILTB/SUBTC/FILTC/TRIGA update of one channel's DMS, DML and AP
module asc_update
  import asc_pkg::*;
(
  input  logic [3:0]       cw_i,
  input  logic [Y_W-1:0]   y_i,
  input  logic             tdp_i,
  input  logic             tr_i,
  input  logic [DMS_W-1:0] dms_i,
  input  logic [DML_W-1:0] dml_i,
  input  logic [AP_W-1:0]  ap_i,
  output logic [DMS_W-1:0] dmsp_o,
  output logic [DML_W-1:0] dmlp_o,
  output logic [AP_W-1:0]  apr_o
);
  logic [2:0] im, fi;
  logic signed [DMS_W:0] dms_diff, dms_sh;
  logic signed [DML_W:0] dml_diff, dml_sh;
  logic signed [14:0] dif;
  logic [14:0] difm;
  logic ax;
  logic signed [AP_W:0] ap_diff, ap_sh;
  // Arithmetic shifts keep the difference sign, so negative steps round toward minus infinity
  always_comb begin
    im = cw_i[3] ? ~cw_i[2:0] : cw_i[2:0];
    fi = FI_TAB[im];
    dms_diff = {1'b0, fi, 9'b0} - {1'b0, dms_i};
    dms_sh = dms_diff >>> 5;
    dmsp_o = dms_i + dms_sh[DMS_W-1:0];
    dml_diff = {1'b0, fi, 11'b0} - {1'b0, dml_i};
    dml_sh = dml_diff >>> 7;
    dmlp_o = dml_i + dml_sh[DML_W-1:0];
    dif = {1'b0, dmsp_o, 2'b0} - {1'b0, dmlp_o};
    difm = dif[14] ? -dif : dif;
    ax = !(y_i >= Y_THR && difm < {4'b0, dmlp_o[DML_W-1:3]} && !tdp_i);
    ap_diff = {1'b0, ax, 9'b0} - {1'b0, ap_i};
    ap_sh = ap_diff >>> 4;
    apr_o = tr_i ? AP_TR : ap_i + ap_sh[AP_W-1:0];
  end
endmodule

// File: rtl/asc_state_unit.sv
// asc_state_unit: per-channel DMS/DML/AP state with a two-stage accept / read-update-write pipeline
module asc_state_unit
  import asc_pkg::*;
#(
  parameter int NCH = 32,
  parameter int CHW = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            IN_VALID,
  input  logic [CHW-1:0]  CH,
  input  logic [3:0]      I,
  input  logic [Y_W-1:0]  Y,
  input  logic            TDP,
  input  logic            TR,
  output logic            AP_VALID,
  output logic [AP_W-1:0] AP_OUT,
  output logic [AP_W-1:0] APR_OUT
);
  logic [DMS_W-1:0] dms_q [NCH];
  logic [DML_W-1:0] dml_q [NCH];
  logic [AP_W-1:0]  ap_q  [NCH];
  logic             v_q, tdp_q, tr_q;
  logic [CHW-1:0]   ch_q;
  logic [3:0]       cw_q;
  logic [Y_W-1:0]   y_q;
  logic             fw_v_q;
  logic [CHW-1:0]   fw_ch_q;
  logic [DMS_W-1:0] fw_dms_q, dms_cur, dms_d;
  logic [DML_W-1:0] fw_dml_q, dml_cur, dml_d;
  logic [AP_W-1:0]  fw_ap_q, ap_cur, ap_d;
  logic             ap_valid_q;
  logic [AP_W-1:0]  ap_out_q, apr_out_q;
  logic             in_range, fwd;
  // Out-of-range requests are dropped at accept so they never reach the state arrays
  assign in_range = {1'b0, CH} < (CHW+1)'(NCH);
  assign fwd      = fw_v_q && fw_ch_q == ch_q;
  assign dms_cur  = fwd ? fw_dms_q : dms_q[ch_q];
  assign dml_cur  = fwd ? fw_dml_q : dml_q[ch_q];
  assign ap_cur   = fwd ? fw_ap_q  : ap_q[ch_q];
  asc_update u_upd (
    .cw_i   (cw_q),
    .y_i    (y_q),
    .tdp_i  (tdp_q),
    .tr_i   (tr_q),
    .dms_i  (dms_cur),
    .dml_i  (dml_cur),
    .ap_i   (ap_cur),
    .dmsp_o (dms_d),
    .dmlp_o (dml_d),
    .apr_o  (ap_d)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        dms_q[k] <= '0;
        dml_q[k] <= '0;
        ap_q[k]  <= '0;
      end
      v_q        <= 1'b0;
      ch_q       <= '0;
      cw_q       <= '0;
      y_q        <= '0;
      tdp_q      <= 1'b0;
      tr_q       <= 1'b0;
      fw_v_q     <= 1'b0;
      fw_ch_q    <= '0;
      fw_dms_q   <= '0;
      fw_dml_q   <= '0;
      fw_ap_q    <= '0;
      ap_valid_q <= 1'b0;
      ap_out_q   <= '0;
      apr_out_q  <= '0;
    end else begin
      v_q        <= IN_VALID && in_range;
      ap_valid_q <= v_q;
      fw_v_q     <= v_q;
      if (IN_VALID && in_range) begin
        ch_q  <= CH;
        cw_q  <= I;
        y_q   <= Y;
        tdp_q <= TDP;
        tr_q  <= TR;
      end
      if (v_q) begin
        dms_q[ch_q] <= dms_d;
        dml_q[ch_q] <= dml_d;
        ap_q[ch_q]  <= ap_d;
        fw_ch_q     <= ch_q;
        fw_dms_q    <= dms_d;
        fw_dml_q    <= dml_d;
        fw_ap_q     <= ap_d;
        ap_out_q    <= ap_cur;
        apr_out_q   <= ap_d;
      end
    end
  end
  assign AP_VALID = ap_valid_q;
  assign AP_OUT   = ap_out_q;
  assign APR_OUT  = apr_out_q;
endmodule

// File: tb/tb_asc_state_unit.sv
// tb_asc_state_unit: directed requests with hand-computed AP results checked through a scoreboard queue
module tb_asc_state_unit;
  import asc_pkg::*;
  typedef struct packed {
    logic        chk;
    logic [9:0]  ap;
    logic [9:0]  apr;
    logic [15:0] id;
  } exp_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic in_valid = 1'b0, s_in_valid = 1'b0;
  logic [4:0] in_ch = '0, s_ch = '0;
  logic [3:0] in_cw = '0;
  logic [12:0] in_y = '0;
  logic in_tdp = 1'b0, in_tr = 1'b0;
  logic ap_valid, s_ap_valid;
  logic [9:0] ap_out, apr_out, s_ap_out, s_apr_out;
  exp_t q[$];
  int total = 0, bad = 0, nid = 0, s_cnt = 0;

  always #5 clk = ~clk;

  asc_state_unit dut (
    .clk(clk), .reset_n(reset_n), .IN_VALID(in_valid), .CH(in_ch), .I(in_cw), .Y(in_y),
    .TDP(in_tdp), .TR(in_tr), .AP_VALID(ap_valid), .AP_OUT(ap_out), .APR_OUT(apr_out)
  );
  asc_state_unit #(.NCH(24), .CHW(5)) dut_small (
    .clk(clk), .reset_n(reset_n), .IN_VALID(s_in_valid), .CH(s_ch), .I(in_cw), .Y(in_y),
    .TDP(in_tdp), .TR(in_tr), .AP_VALID(s_ap_valid), .AP_OUT(s_ap_out), .APR_OUT(s_apr_out)
  );

  task automatic cmp(input string nm, input int id, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s #%0d: got %0d expected %0d", nm, id, act, want);
    end
  endtask

  task automatic req(input logic [4:0] c, input logic [3:0] cw, input logic [12:0] y,
                     input logic tdp, input logic tr, input logic chk,
                     input logic [9:0] ea, input logic [9:0] er);
    in_valid = 1'b1; in_ch = c; in_cw = cw; in_y = y; in_tdp = tdp; in_tr = tr;
    q.push_back('{chk: chk, ap: ea, apr: er, id: 16'(nid)});
    nid++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clk); n++;
    end
    #1;
    if (q.size() > 0) begin
      cmp("drain_timeout", nid, 16'(q.size()), 16'd0);
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (s_ap_valid) s_cnt++;
    if (ap_valid) begin
      if (q.size() == 0) cmp("unexpected_valid", nid, 16'd1, 16'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk) begin
          cmp("ap_out", int'(e.id), 16'(ap_out), 16'(e.ap));
          cmp("apr_out", int'(e.id), 16'(apr_out), 16'(e.apr));
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_valid", 0, 16'(ap_valid), 16'd0);
    cmp("rst_ap", 0, 16'(ap_out), 16'd0);
    cmp("rst_apr", 0, 16'(apr_out), 16'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    req(5'd3, 4'd7, 13'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd32);
    drain();
    cmp("dms3", 3, 16'(dut.dms_q[3]), 16'd112);
    cmp("dml3", 3, 16'(dut.dml_q[3]), 16'd112);
    req(5'd3, 4'd7, 13'd0, 1'b0, 1'b0, 1'b1, 10'd32, 10'd62);
    drain();
    cmp("dml3_b", 3, 16'(dut.dml_q[3]), 16'd223);
    cmp("dms3_b", 3, 16'(dut.dms_q[3]), 16'd220);
    req(5'd4, 4'd7, 13'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd32);
    req(5'd4, 4'd0, 13'd0, 1'b0, 1'b0, 1'b1, 10'd32, 10'd62);
    drain();
    cmp("dml4_neg", 4, 16'(dut.dml_q[4]), 16'd111);
    cmp("dms4_neg", 4, 16'(dut.dms_q[4]), 16'd108);
    req(5'd5, 4'd7, 13'd0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd256);
    req(5'd5, 4'd7, 13'd0, 1'b0, 1'b0, 1'b1, 10'd256, 10'd272);
    req(5'd6, 4'd0, 13'd1536, 1'b0, 1'b0, 1'b1, 10'd0, 10'd32);
    req(5'd7, 4'd0, 13'd1535, 1'b0, 1'b0, 1'b1, 10'd0, 10'd32);
    drain();
    cmp("dml6_zero", 6, 16'(dut.dml_q[6]), 16'd0);
    // Long I=7 run settles AP at 497 and brings 4*DMS close enough to DML for AX=0
    for (int n = 0; n < 600; n++)
      req(5'd10, 4'd7, 13'd0, 1'b0, 1'b0, n >= 80, 10'd497, 10'd497);
    req(5'd10, 4'd7, 13'd2000, 1'b0, 1'b0, 1'b1, 10'd497, 10'd465);
    req(5'd10, 4'd7, 13'd2000, 1'b1, 1'b0, 1'b1, 10'd465, 10'd467);
    req(5'd10, 4'd7, 13'd2000, 1'b0, 1'b0, 1'b1, 10'd467, 10'd437);
    req(5'd10, 4'd7, 13'd1535, 1'b0, 1'b0, 1'b1, 10'd437, 10'd441);
    req(5'd10, 4'd7, 13'd1536, 1'b0, 1'b0, 1'b1, 10'd441, 10'd413);
    req(5'd0,  4'd7, 13'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd32);
    req(5'd31, 4'd0, 13'd0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd256);
    req(5'd0,  4'd7, 13'd0, 1'b0, 1'b0, 1'b1, 10'd32, 10'd62);
    req(5'd31, 4'd0, 13'd0, 1'b0, 1'b0, 1'b1, 10'd256, 10'd272);
    req(5'd0,  4'd7, 13'd0, 1'b0, 1'b0, 1'b1, 10'd62, 10'd90);
    drain();
    in_valid = 1'b1; in_ch = 5'd0; in_cw = 4'd7; in_y = '0; in_tdp = 1'b0; in_tr = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    cmp("midrst_valid", 0, 16'(ap_valid), 16'd0);
    cmp("midrst_ap", 0, 16'(ap_out), 16'd0);
    cmp("midrst_apr", 0, 16'(apr_out), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("midrst_dml10", 10, 16'(dut.dml_q[10]), 16'd0);
    req(5'd0,  4'd7, 13'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd32);
    req(5'd31, 4'd7, 13'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd32);
    req(5'd3,  4'd7, 13'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd32);
    req(5'd10, 4'd7, 13'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd32);
    drain();
    s_cnt = 0;
    in_cw = 4'd7; in_y = '0; in_tdp = 1'b0; in_tr = 1'b0;
    s_in_valid = 1'b1; s_ch = 5'd30;
    @(posedge clk); #1;
    s_ch = 5'd5;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    cmp("range_valid_cnt", 30, 16'(s_cnt), 16'd1);
    cmp("range_ap", 5, 16'(s_ap_out), 16'd0);
    cmp("range_apr", 5, 16'(s_apr_out), 16'd32);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
